// File: rtl/conv1_pkg.sv
// conv1_pkg: types and constants shared by the conv1 pool row-pair buffer.
//   pixel_t      - signed pixel at the default operand width
//   state_t      - row-pair buffer control states
//   *_DEF        - default geometry constants
//   idx_w()      - counter/index width helper (never narrower than 1 bit)
package conv1_pkg;

  localparam int unsigned OPERAND_WDTH_DEF   = 22;
  localparam int unsigned NUM_PIXELS_BUF_DEF = 4;
  localparam int unsigned IMG_WDTH_DEF       = 28;
  localparam int unsigned IMG_HGHT_DEF       = 28;

  typedef logic signed [OPERAND_WDTH_DEF-1:0] pixel_t;

  typedef enum logic [1:0] {
    FILL_EVEN,
    FILL_ODD,
    OUT_HOLD
  } state_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv1_line_mem.sv
// conv1_line_mem: one-row line buffer for the conv1 pool row-pair buffer.
//   clk      - write clock
//   wr_en    - write strobe
//   wr_addr  - column being written
//   wr_data  - pixel to store
//   rd_grp   - column-group index for the wide read
//   rd_data  - NUM_PIXELS_BUF pixels of group rd_grp, index 0 = leftmost
// Storage has no reset; contents are don't-care until written.
module conv1_line_mem
  import conv1_pkg::*;
#(
  parameter int unsigned OPERAND_WDTH   = OPERAND_WDTH_DEF,
  parameter int unsigned NUM_PIXELS_BUF = NUM_PIXELS_BUF_DEF,
  parameter int unsigned IMG_WDTH       = IMG_WDTH_DEF
) (
  input  logic                                           clk,
  input  logic                                           wr_en,
  input  logic [idx_w(IMG_WDTH)-1:0]                     wr_addr,
  input  logic [OPERAND_WDTH-1:0]                        wr_data,
  input  logic [idx_w(IMG_WDTH/NUM_PIXELS_BUF)-1:0]      rd_grp,
  output logic [NUM_PIXELS_BUF-1:0][OPERAND_WDTH-1:0]    rd_data
);

  localparam int unsigned ADDR_W = idx_w(IMG_WDTH);

  logic [OPERAND_WDTH-1:0] mem [IMG_WDTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_PIXELS_BUF; i++) begin
      rd_data[i] = mem[ADDR_W'(32'(rd_grp) * NUM_PIXELS_BUF + i)];
    end
  end

endmodule

// File: rtl/conv1_pool_row_buf.sv
// conv1_pool_row_buf: streaming row-pair buffer feeding the conv1 max-pool.
// Even rows are stored in a line buffer; while the following odd row streams
// in, each completed NUM_PIXELS_BUF-wide column group is emitted together with
// the matching group of the stored even row.
//   conv1_pbuf_clk  - clock
//   conv1_pbuf_rst  - asynchronous active-high reset
//   pix_i/pix_vld_i/pix_rdy_o       - raster-order pixel input handshake
//   pool_a_o        - upper (even) row group, index 0 = leftmost column
//   pool_b_o        - lower (odd) row group, same alignment
//   pool_vld_o/pool_rdy_i           - output beat handshake
//   frame_done_o    - one-cycle pulse after the last beat of a frame
// Build option: define CONV1_PBUF_RELU_EN to clamp negative input pixels to 0.
module conv1_pool_row_buf
  import conv1_pkg::*;
#(
  parameter int unsigned OPERAND_WDTH   = OPERAND_WDTH_DEF,
  parameter int unsigned NUM_PIXELS_BUF = NUM_PIXELS_BUF_DEF,
  parameter int unsigned IMG_WDTH       = IMG_WDTH_DEF,
  parameter int unsigned IMG_HGHT       = IMG_HGHT_DEF
) (
  input  logic                                         conv1_pbuf_clk,
  input  logic                                         conv1_pbuf_rst,
  input  logic [OPERAND_WDTH-1:0]                      pix_i,
  input  logic                                         pix_vld_i,
  output logic                                         pix_rdy_o,
  output logic [NUM_PIXELS_BUF-1:0][OPERAND_WDTH-1:0]  pool_a_o,
  output logic [NUM_PIXELS_BUF-1:0][OPERAND_WDTH-1:0]  pool_b_o,
  output logic                                         pool_vld_o,
  input  logic                                         pool_rdy_i,
  output logic                                         frame_done_o
);

  localparam int unsigned NUM_GRPS = IMG_WDTH / NUM_PIXELS_BUF;
  localparam int unsigned COL_W    = idx_w(IMG_WDTH);
  localparam int unsigned GRP_W    = idx_w(NUM_GRPS);
  localparam int unsigned SLOT_W   = idx_w(NUM_PIXELS_BUF);
  localparam int unsigned ROW_W    = idx_w(IMG_HGHT / 2);

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_WDTH - 1);
  localparam logic [GRP_W-1:0]  GRP_LAST  = GRP_W'(NUM_GRPS - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_PIXELS_BUF - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_HGHT / 2 - 1);

  typedef logic [NUM_PIXELS_BUF-1:0][OPERAND_WDTH-1:0] group_t;

  state_t             state;
  logic [COL_W-1:0]   col_cnt;
  logic [ROW_W-1:0]   row_cnt;
  logic [SLOT_W-1:0]  slot;
  logic [GRP_W-1:0]   grp;
  logic               last_grp;
  group_t             grp_reg;
  group_t             grp_full;
  group_t             lb_rd;
  logic [OPERAND_WDTH-1:0] pix_in;
  logic               pix_acc;
  logic               beat_acc;

`ifdef CONV1_PBUF_RELU_EN
  assign pix_in = pix_i[OPERAND_WDTH-1] ? '0 : pix_i;
`else
  assign pix_in = pix_i;
`endif

  // Ready is a decode of the registered state, gated by reset so it reads 0
  // while reset is held and 1 in the first cycle after release.
  assign pix_rdy_o = ~conv1_pbuf_rst & (state != OUT_HOLD);
  assign pix_acc   = pix_vld_i & pix_rdy_o;
  assign beat_acc  = pool_vld_o & pool_rdy_i;

  // Slot and group counters run alongside col_cnt so the group index needs no
  // division when NUM_PIXELS_BUF is not a power of two.
  always_comb begin
    grp_full       = grp_reg;
    grp_full[slot] = pix_in;
  end

  conv1_line_mem #(
    .OPERAND_WDTH   (OPERAND_WDTH),
    .NUM_PIXELS_BUF (NUM_PIXELS_BUF),
    .IMG_WDTH       (IMG_WDTH)
  ) u_line_mem (
    .clk     (conv1_pbuf_clk),
    .wr_en   (pix_acc & (state == FILL_EVEN)),
    .wr_addr (col_cnt),
    .wr_data (pix_in),
    .rd_grp  (grp),
    .rd_data (lb_rd)
  );

  always_ff @(posedge conv1_pbuf_clk or posedge conv1_pbuf_rst) begin
    if (conv1_pbuf_rst) begin
      state        <= FILL_EVEN;
      col_cnt      <= '0;
      row_cnt      <= '0;
      slot         <= '0;
      grp          <= '0;
      last_grp     <= 1'b0;
      grp_reg      <= '0;
      pool_a_o     <= '0;
      pool_b_o     <= '0;
      pool_vld_o   <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      case (state)
        FILL_EVEN: begin
          if (pix_acc) begin
            if (col_cnt == COL_LAST) begin
              col_cnt <= '0;
              slot    <= '0;
              grp     <= '0;
              state   <= FILL_ODD;
            end else begin
              col_cnt <= col_cnt + 1'b1;
            end
          end
        end

        FILL_ODD: begin
          if (pix_acc) begin
            grp_reg <= grp_full;
            col_cnt <= (col_cnt == COL_LAST) ? '0 : col_cnt + 1'b1;
            if (slot == SLOT_LAST) begin
              slot       <= '0;
              pool_b_o   <= grp_full;
              pool_a_o   <= lb_rd;
              pool_vld_o <= 1'b1;
              last_grp   <= (grp == GRP_LAST);
              grp        <= (grp == GRP_LAST) ? '0 : grp + 1'b1;
              state      <= OUT_HOLD;
            end else begin
              slot <= slot + 1'b1;
            end
          end
        end

        OUT_HOLD: begin
          if (beat_acc) begin
            pool_vld_o <= 1'b0;
            if (last_grp) begin
              col_cnt <= '0;
              state   <= FILL_EVEN;
              if (row_cnt == ROW_LAST) begin
                row_cnt      <= '0;
                frame_done_o <= 1'b1;
              end else begin
                row_cnt <= row_cnt + 1'b1;
              end
            end else begin
              state <= FILL_ODD;
            end
          end
        end

        default: state <= FILL_EVEN;
      endcase
    end
  end

endmodule

// File: tb/tb_conv1_pool_row_buf.sv
// Scoreboard bench for conv1_pool_row_buf at an 8x4 frame, 4-pixel groups.
// Expected beats are derived from a frame image held in the bench and pushed
// when the driver sees the group's final odd-row pixel transfer; a monitor on
// the falling edge pops and compares every presented beat.
module tb_conv1_pool_row_buf;

  localparam int unsigned W  = 22;
  localparam int unsigned N  = 4;
  localparam int unsigned IW = 8;
  localparam int unsigned IH = 4;

  typedef logic [N-1:0][W-1:0] grp_t;
  typedef struct {
    grp_t        a;
    grp_t        b;
    int unsigned cyc;
    bit          last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [W-1:0] pix = '0;
  logic        pix_vld = 1'b0;
  logic        pix_rdy;
  grp_t        pool_a;
  grp_t        pool_b;
  logic        pool_vld;
  logic        pool_rdy = 1'b0;
  logic        frame_done;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;
  int          hold_len = 0;
  int          rdy_gap  = 0;
  int          pos      = 0;
  logic [W-1:0] img [IH][IW];
  beat_t       sb[$];

  conv1_pool_row_buf #(
    .OPERAND_WDTH   (W),
    .NUM_PIXELS_BUF (N),
    .IMG_WDTH       (IW),
    .IMG_HGHT       (IH)
  ) dut (
    .conv1_pbuf_clk (clk),
    .conv1_pbuf_rst (rst),
    .pix_i          (pix),
    .pix_vld_i      (pix_vld),
    .pix_rdy_o      (pix_rdy),
    .pool_a_o       (pool_a),
    .pool_b_o       (pool_b),
    .pool_vld_o     (pool_vld),
    .pool_rdy_i     (pool_rdy),
    .frame_done_o   (frame_done)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] model_pix(input logic [W-1:0] p);
`ifdef CONV1_PBUF_RELU_EN
    return p[W-1] ? '0 : p;
`else
    return p;
`endif
  endfunction

  // mode 0: row*16+col, mode 1: random, mode 2: row*16+col with pixel 0 = -5
  task automatic gen_img(input int mode);
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++)
        img[r][c] = (mode == 1) ? W'($urandom) : W'(r * 16 + c);
    if (mode == 2) img[0][0] = W'(-5);
  endtask

  task automatic send_px(input int count, input int mode, input int gap);
    for (int k = 0; k < count; k++) begin
      int r, c, tries;
      bit done;
      if (pos == 0) gen_img(mode);
      r = pos / IW;
      c = pos % IW;
      done = 0;
      tries = 0;
      while (!done) begin
        @(posedge clk); #1;
        tries++;
        if (tries > 500) begin
          $display("FAIL driver_timeout: pixel %0d never accepted", pos);
          bad++;
          $display("test done: total=%0d bad=%0d", total, bad);
          $fatal(1, "driver stalled");
        end
        if ($urandom_range(99) < gap) begin
          pix_vld = 1'b0;
          pix     = W'($urandom);
        end else begin
          pix_vld = 1'b1;
          pix     = img[r][c];
          if (pix_rdy) begin
            done = 1;
            if ((r % 2 == 1) && (c % N == N - 1)) begin
              beat_t e;
              for (int i = 0; i < N; i++) begin
                e.a[i] = model_pix(img[r-1][c-N+1+i]);
                e.b[i] = model_pix(img[r][c-N+1+i]);
              end
              e.cyc  = cyc + 1;
              e.last = (r == IH - 1) && (c == IW - 1);
              sb.push_back(e);
            end
            pos = (pos + 1) % (IW * IH);
          end
        end
      end
    end
    @(posedge clk); #1;
    pix_vld = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Consumer: holds ready low for hold_len cycles of each beat, otherwise random.
  initial begin
    int held;
    held = 0;
    forever begin
      @(posedge clk); #1;
      if (!pool_vld) held = 0;
      if (pool_vld && held < hold_len) begin
        pool_rdy = 1'b0;
        held++;
      end else begin
        pool_rdy = ($urandom_range(99) >= rdy_gap);
      end
    end
  end

  // Monitor
  initial begin
    beat_t cur;
    bit prev, fd_exp, rdy_chk;
    prev = 0; fd_exp = 0; rdy_chk = 0;
    cur = '{a: '0, b: '0, cyc: 0, last: 0};
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_pix_rdy", pix_rdy, 0);
        chk("rst_pool_vld", pool_vld, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_pool_a", pool_a, 0);
        chk("rst_pool_b", pool_b, 0);
        prev = 0; fd_exp = 0; rdy_chk = 0;
      end else begin
        chk("frame_done", frame_done, fd_exp);
        fd_exp = 0;
        if (rdy_chk) chk("pix_rdy_after_accept", pix_rdy, 1);
        rdy_chk = 0;
        if (pool_vld) begin
          if (!prev) begin
            if (sb.size() == 0) begin
              total++; bad++;
              $display("FAIL unexpected_beat: got a=%h b=%h want no beat", pool_a, pool_b);
              cur = '{a: '0, b: '0, cyc: 0, last: 0};
            end else begin
              cur = sb.pop_front();
              chk("beat_a", pool_a, cur.a);
              chk("beat_b", pool_b, cur.b);
              chk("beat_latency", cyc, cur.cyc);
            end
          end else begin
            chk("hold_a", pool_a, cur.a);
            chk("hold_b", pool_b, cur.b);
          end
          chk("pix_rdy_in_hold", pix_rdy, 0);
          prev = 1;
          if (pool_rdy) begin
            fd_exp  = cur.last;
            rdy_chk = 1;
            prev    = 0;
          end
        end else begin
          prev = 0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("rdy_after_reset", pix_rdy, 1);

    // Two beats of the first row pair, then the rest of the frame
    hold_len = 0; rdy_gap = 0;
    send_px(16, 0, 0);
    drain();
    send_px(16, 0, 0);
    drain();

    // Next frame with the consumer stalling 5 cycles on each beat
    hold_len = 5;
    send_px(32, 0, 0);
    drain();
    hold_len = 0;

    // Random data and handshake gaps over three frames
    rdy_gap = 30;
    send_px(96, 1, 50);
    drain();
    rdy_gap = 0;

    // Reset mid-frame, then a fresh frame
    send_px(11, 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    pos = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    send_px(32, 0, 0);
    drain();

    // Negative leading pixel
    send_px(32, 2, 0);
    drain();

    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
